// File: rtl/fpalu_pipe.sv
// Three-stage pipelined floating-point ALU (add/sub/mul/pass) with valid/ready backpressure.
// Value = (-1)^sgn * (man / 2^MAN_W) * 2^(exp - BIAS); mantissa left-aligned, no hidden bit.
module fpalu_pipe #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 22,
    parameter int BIAS  = 2**(EXP_W-1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             a_sgn,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [MAN_W-1:0] a_man_dn,
    input  logic             b_sgn,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [MAN_W-1:0] b_man_dn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y_sgn,
    output logic [EXP_W-1:0] y_exp,
    output logic [MAN_W-1:0] y_man_dn,
    output logic             y_ovf,
    output logic             y_unf
);
    localparam int EW  = EXP_W + 2;
    localparam int PW  = 2 * MAN_W;
    localparam int LZW = $clog2(PW + 1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    op_e  op_in;
    logic adv;

    assign op_in    = op_e'(op);
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage 1: align/compare for add/sub, full product for mul
    logic                 s1_vld_q;
    logic                 s1_sgn_d, s1_sgn_q;
    logic                 s1_arith_d, s1_arith_q;
    logic                 s1_sub_d, s1_sub_q;
    logic signed [EW-1:0] s1_exp_d, s1_exp_q;
    logic [PW-1:0]        s1_x_d, s1_x_q;
    logic [MAN_W-1:0]     s1_s_d, s1_s_q;

    logic             b_sgn_eff, a_big;
    logic [EXP_W-1:0] e_diff;
    logic [MAN_W-1:0] l_man, s_man;

    always_comb begin
        b_sgn_eff  = b_sgn ^ (op_in == OP_SUB);
        a_big      = (a_exp > b_exp) || ((a_exp == b_exp) && (a_man_dn >= b_man_dn));
        l_man      = a_big ? a_man_dn : b_man_dn;
        s_man      = a_big ? b_man_dn : a_man_dn;
        e_diff     = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
        s1_sgn_d   = a_sgn;
        s1_arith_d = 1'b0;
        s1_sub_d   = 1'b0;
        s1_exp_d   = EW'(a_exp);
        s1_x_d     = {a_man_dn, {MAN_W{1'b0}}};
        s1_s_d     = '0;
        case (op_in)
            OP_ADD, OP_SUB: begin
                s1_arith_d = 1'b1;
                s1_sgn_d   = a_big ? a_sgn : b_sgn_eff;
                s1_sub_d   = a_sgn ^ b_sgn_eff;
                s1_exp_d   = EW'(a_big ? a_exp : b_exp);
                s1_x_d     = {l_man, {MAN_W{1'b0}}};
                // Shifts of MAN_W or more already yield zero
                s1_s_d     = s_man >> e_diff;
            end
            OP_MUL: begin
                s1_sgn_d = a_sgn ^ b_sgn;
                s1_exp_d = EW'(a_exp) + EW'(b_exp) - EW'(BIAS);
                s1_x_d   = PW'(a_man_dn) * PW'(b_man_dn);
            end
            default: ;
        endcase
    end

    // Stage 2: add/sub, carry fold, leading-zero count over the PW-bit value
    logic                 s2_vld_q;
    logic                 s2_sgn_q;
    logic signed [EW-1:0] s2_exp_d, s2_exp_q;
    logic [PW-1:0]        s2_x_d, s2_x_q;
    logic [LZW-1:0]       s2_lz_d, s2_lz_q;
    logic [MAN_W:0]       sum;

    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_x_q[PW-1 -: MAN_W]} - {1'b0, s1_s_q})
                       : ({1'b0, s1_x_q[PW-1 -: MAN_W]} + {1'b0, s1_s_q});
        s2_x_d   = s1_x_q;
        s2_exp_d = s1_exp_q;
        if (s1_arith_q) begin
            if (sum[MAN_W] && !s1_sub_q) begin
                s2_x_d   = {sum[MAN_W:1], {MAN_W{1'b0}}};
                s2_exp_d = s1_exp_q + EW'(1);
            end else begin
                s2_x_d = {sum[MAN_W-1:0], {MAN_W{1'b0}}};
            end
        end
        s2_lz_d = LZW'(PW);
        for (int unsigned i = 0; i < PW; i++) begin
            if (s2_x_d[i]) s2_lz_d = LZW'(PW - 1 - i);
        end
    end

    // Stage 3: normalise, exponent adjust, saturate/flush
    logic                 y_sgn_d, y_ovf_d, y_unf_d;
    logic [EXP_W-1:0]     y_exp_d;
    logic [MAN_W-1:0]     y_man_d;
    logic signed [EW-1:0] exp_n;

    always_comb begin
        exp_n   = s2_exp_q - EW'(s2_lz_q);
        y_sgn_d = s2_sgn_q;
        y_exp_d = exp_n[EXP_W-1:0];
        y_man_d = MAN_W'((s2_x_q << s2_lz_q) >> MAN_W);
        y_ovf_d = 1'b0;
        y_unf_d = 1'b0;
        if (s2_x_q == '0) begin
            y_sgn_d = 1'b0;
            y_exp_d = '0;
            y_man_d = '0;
        end else if (exp_n > EXP_MAX) begin
            y_exp_d = '1;
            y_man_d = '1;
            y_ovf_d = 1'b1;
        end else if (exp_n[EW-1]) begin
            y_sgn_d = 1'b0;
            y_exp_d = '0;
            y_man_d = '0;
            y_unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_sgn_q   <= 1'b0;
            s1_arith_q <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_exp_q   <= '0;
            s1_x_q     <= '0;
            s1_s_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_sgn_q   <= 1'b0;
            s2_exp_q   <= '0;
            s2_x_q     <= '0;
            s2_lz_q    <= '0;
            out_valid  <= 1'b0;
            y_sgn      <= 1'b0;
            y_exp      <= '0;
            y_man_dn   <= '0;
            y_ovf      <= 1'b0;
            y_unf      <= 1'b0;
        end else if (adv) begin
            s1_vld_q   <= in_valid;
            s1_sgn_q   <= s1_sgn_d;
            s1_arith_q <= s1_arith_d;
            s1_sub_q   <= s1_sub_d;
            s1_exp_q   <= s1_exp_d;
            s1_x_q     <= s1_x_d;
            s1_s_q     <= s1_s_d;
            s2_vld_q   <= s1_vld_q;
            s2_sgn_q   <= s1_sgn_q;
            s2_exp_q   <= s2_exp_d;
            s2_x_q     <= s2_x_d;
            s2_lz_q    <= s2_lz_d;
            out_valid  <= s2_vld_q;
            y_sgn      <= y_sgn_d;
            y_exp      <= y_exp_d;
            y_man_dn   <= y_man_d;
            y_ovf      <= y_ovf_d;
            y_unf      <= y_unf_d;
        end
    end

endmodule

// File: tb/tb_fpalu_pipe.sv
// Randomised and directed bench for fpalu_pipe: value-level reference model plus in-order scoreboard.
module tb_fpalu_pipe;
    localparam int EXP_W = 6;
    localparam int MAN_W = 22;
    localparam int BIAS  = 32;
    localparam int RW    = MAN_W + EXP_W + 3;
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_PASS = 2'b11;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } fp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [1:0]       op;
    logic             a_sgn, b_sgn, y_sgn, y_ovf, y_unf;
    logic [EXP_W-1:0] a_exp, b_exp, y_exp;
    logic [MAN_W-1:0] a_man_dn, b_man_dn, y_man_dn;
    logic [RW-1:0]    y_obs;

    always #5 clk = ~clk;

    fpalu_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a_sgn(a_sgn), .a_exp(a_exp), .a_man_dn(a_man_dn),
        .b_sgn(b_sgn), .b_exp(b_exp), .b_man_dn(b_man_dn),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_sgn(y_sgn), .y_exp(y_exp), .y_man_dn(y_man_dn), .y_ovf(y_ovf), .y_unf(y_unf)
    );

    assign y_obs = {y_ovf, y_unf, y_sgn, y_exp, y_man_dn};

    logic [RW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_rx  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: form the exact value v/2^f * 2^(e-BIAS), then place its leading one at the mantissa MSB.
    function automatic logic [RW-1:0] model(input logic [1:0] o, input fp_t a, input fp_t b);
        logic [63:0] v;
        int e, f, pos, diff;
        logic s;
        fp_t l, sm;
        case (o)
            OP_MUL: begin
                s = a.s ^ b.s; v = 64'(a.m) * 64'(b.m);
                e = int'(a.e) + int'(b.e) - BIAS; f = 2 * MAN_W;
            end
            OP_PASS: begin
                s = a.s; v = 64'(a.m); e = int'(a.e); f = MAN_W;
            end
            default: begin
                b.s = b.s ^ (o == OP_SUB);
                if (a.e > b.e || (a.e == b.e && a.m >= b.m)) begin l = a; sm = b; end
                else begin l = b; sm = a; end
                diff = int'(l.e) - int'(sm.e);
                v = 64'(sm.m) >> diff;
                v = (l.s == sm.s) ? 64'(l.m) + v : 64'(l.m) - v;
                s = l.s; e = int'(l.e); f = MAN_W;
            end
        endcase
        if (v == 64'd0) return '0;
        pos = 63;
        while (!v[pos]) pos--;
        e = e + pos + 1 - f;
        if (pos >= MAN_W - 1) v = v >> (pos - MAN_W + 1);
        else                  v = v << (MAN_W - 1 - pos);
        if (e > 2**EXP_W - 1) return {2'b10, s, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
        if (e < 0)            return {2'b01, 1'b0, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
        return {2'b00, s, e[EXP_W-1:0], v[MAN_W-1:0]};
    endfunction

    function automatic fp_t rand_fp(input logic norm);
        fp_t x;
        x.s = 1'($urandom);
        x.e = EXP_W'($urandom);
        x.m = MAN_W'($urandom);
        if (norm) x.m[MAN_W-1] = 1'b1;
        else if ($urandom_range(0, 7) == 0) x.m = x.m >> $urandom_range(1, MAN_W);
        return x;
    endfunction

    // Results in flight come out in order; a stalled result must already equal the head entry.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) check_val("spurious_valid", 64'(out_valid), 64'd0);
            else if (out_ready) begin
                check_val("result", 64'(y_obs), 64'(exp_q.pop_front()));
                n_rx++;
            end else check_val("stall_hold", 64'(y_obs), 64'(exp_q[0]));
        end
    end

    task automatic drive_cycle(input logic v, input logic [1:0] o, input fp_t a, input fp_t b,
                               input logic ordy, output logic acc);
        in_valid = v; op = o; out_ready = ordy;
        {a_sgn, a_exp, a_man_dn} = a;
        {b_sgn, b_exp, b_man_dn} = b;
        @(negedge clk); #1;
        acc = v && in_ready;
        if (acc) exp_q.push_back(model(o, a, b));
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [1:0] o, input fp_t a, input fp_t b);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) drive_cycle(1'b1, o, a, b, 1'b1, acc);
        if (!acc) check_val("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, OP_ADD, '0, '0, 1'b1, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) drive_cycle(1'b0, OP_ADD, '0, '0, 1'b1, acc);
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish before it");
        $fatal(1, "watchdog");
    end

    initial begin
        fp_t one, a, b;
        logic [1:0] s_op[8];
        fp_t s_a[8], s_b[8];
        logic acc, v, ordy;
        logic [1:0] o;
        int sent, rx0;

        one = {1'b0, 6'd33, 22'h200000};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = OP_ADD;
        {a_sgn, a_exp, a_man_dn} = '0;
        {b_sgn, b_exp, b_man_dn} = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_y", 64'(y_obs), 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);

        // 1.0 + 1.0 with latency checks
        send(OP_ADD, one, one);
        idle(1);
        check_val("lat_early", 64'(out_valid), 64'd0);
        idle(1);
        check_val("lat3_valid", 64'(out_valid), 64'd1);
        check_val("t1_y", 64'(y_obs), 64'({2'b00, 1'b0, 6'd34, 22'h200000}));
        drain();

        // Directed corner cases
        send(OP_SUB, one, one);
        send(OP_MUL, one, one);
        send(OP_MUL, {1'b0, 6'd63, 22'h200000}, {1'b0, 6'd63, 22'h200000});
        send(OP_MUL, {1'b0, 6'd1, 22'h200000}, {1'b0, 6'd1, 22'h200000});
        send(OP_ADD, one, {1'b1, 6'd31, 22'h300000});
        send(OP_ADD, {1'b0, 6'd0, 22'h0}, one);
        send(OP_MUL, {1'b1, 6'd40, 22'h0}, one);
        send(OP_PASS, {1'b1, 6'd40, 22'h001234}, {1'b1, 6'd7, 22'h3FFFFF});
        send(OP_ADD, {1'b0, 6'd63, 22'h3FFFFF}, {1'b0, 6'd63, 22'h200000});
        send(OP_SUB, {1'b0, 6'd40, 22'h200001}, {1'b0, 6'd40, 22'h200000});
        send(OP_ADD, {1'b0, 6'd50, 22'h200000}, {1'b0, 6'd10, 22'h3FFFFF});
        send(OP_PASS, {1'b0, 6'd2, 22'h000001}, one);
        send(OP_PASS, {1'b1, 6'd5, 22'h0}, one);
        send(OP_MUL, {1'b1, 6'd33, 22'h300000}, {1'b0, 6'd34, 22'h280000});
        drain();
        check_val("t3_sat_model", 64'(model(OP_MUL, {1'b0, 6'd63, 22'h200000}, {1'b0, 6'd63, 22'h200000})),
                  64'({2'b10, 1'b0, 6'h3F, 22'h3FFFFF}));

        // Back-to-back stream with downstream stalled in cycles 4-8
        for (int i = 0; i < 8; i++) begin
            s_op[i] = 2'($urandom);
            s_a[i] = rand_fp(s_op[i][1] == 1'b0);
            s_b[i] = rand_fp(s_op[i][1] == 1'b0);
        end
        sent = 0; rx0 = n_rx;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            if (c == 5) begin
                check_val("full_out_valid", 64'(out_valid), 64'd1);
                check_val("full_in_ready", 64'(in_ready), 64'd0);
            end
            drive_cycle(1'b1, s_op[sent], s_a[sent], s_b[sent], !(c >= 4 && c <= 8), acc);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        drain();
        check_val("stream_count", 64'(n_rx - rx0), 64'd8);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, OP_ADD, one, one, 1'b1, acc);
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        drive_cycle(1'b0, OP_ADD, '0, '0, 1'b1, acc);
        rst_n = 1'b1;
        check_val("midrst_out_valid", 64'(out_valid), 64'd0);
        check_val("midrst_y", 64'(y_obs), 64'd0);
        idle(4);
        send(OP_MUL, one, one);
        idle(1);
        check_val("post_rst_early", 64'(out_valid), 64'd0);
        idle(1);
        check_val("post_rst_valid", 64'(out_valid), 64'd1);
        drain();

        // Random traffic with random backpressure and bubbles
        o = 2'($urandom); a = rand_fp(o[1] == 1'b0); b = rand_fp(o[1] == 1'b0);
        for (int c = 0; c < 600; c++) begin
            v = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            drive_cycle(v, o, a, b, ordy, acc);
            if (acc) begin
                o = 2'($urandom); a = rand_fp(o[1] == 1'b0); b = rand_fp(o[1] == 1'b0);
            end
        end
        in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
